vend_dispenser: RTL and testbench

Product-delivery responder for the vending FSM. It consumes the FSM's dispense outputs (out_coffee, out_sprite) and drives the coffee and sprite dispensing motors for a fixed time. It keeps per-product stock counts and reports sold-out status back to the FSM and LED logic. It runs in the 1 kHz system clock domain, downstream of the vending FSM.

---
 rtl/vend_dispenser_if.sv | 28 ++
 rtl/vend_dispenser.sv | 206 ++++++++++++++++++++
 tb/tb_vend_dispenser.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vend_dispenser_if.sv
// Signal bundle between the vending FSM (master) and the product dispenser (slave).
// Carries dispense/refill requests in one direction and motor/stock status in the other.
interface vend_dispenser_if #(
    parameter int STOCK_W = 4
) ();
    logic               vend_coffee;
    logic               vend_sprite;
    logic               refill;
    logic               motor_coffee;
    logic               motor_sprite;
    logic               busy;
    logic [1:0]         sold_out;
    logic [STOCK_W-1:0] stock_coffee;
    logic [STOCK_W-1:0] stock_sprite;
    logic               drop_err;

    modport master (
        output vend_coffee, vend_sprite, refill,
        input  motor_coffee, motor_sprite, busy, sold_out,
        input  stock_coffee, stock_sprite, drop_err
    );

    modport slave (
        input  vend_coffee, vend_sprite, refill,
        output motor_coffee, motor_sprite, busy, sold_out,
        output stock_coffee, stock_sprite, drop_err
    );
endinterface

// File: rtl/vend_dispenser.sv
// Product-delivery responder: latches coffee/sprite requests, runs one motor at a time
// for RUN_TICKS cycles followed by a GAP_TICKS idle gap, and tracks per-product stock.
module vend_dispenser #(
    parameter int RUN_TICKS  = 500,
    parameter int GAP_TICKS  = 100,
    parameter int STOCK_INIT = 9,
    parameter int STOCK_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    vend_dispenser_if.slave  bus
);
    localparam int TICK_W = 10;
    localparam logic [TICK_W-1:0]  RUN_LAST   = TICK_W'(RUN_TICKS - 1);
    localparam logic [TICK_W-1:0]  GAP_LAST   = TICK_W'(GAP_TICKS - 1);
    localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);
    localparam logic [STOCK_W-1:0] STOCK_NONE = STOCK_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_C = 2'd1,
        ST_RUN_S = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [TICK_W-1:0]   tick_r;
    logic [TICK_W-1:0]   tick_next_s;
    logic                take_c_s;
    logic                take_s_s;

    logic                vend_c_q_r;
    logic                vend_s_q_r;
    logic                pend_c_r;
    logic                pend_s_r;
    logic [STOCK_W-1:0]  stock_c_r;
    logic [STOCK_W-1:0]  stock_s_r;
    logic                motor_c_r;
    logic                motor_s_r;
    logic                drop_err_r;

    logic                rise_c_s;
    logic                rise_s_s;
    logic                set_c_s;
    logic                set_s_s;
    logic                drop_c_s;
    logic                drop_s_s;
    logic                refill_ok_s;

    // Request edge detection, pend acceptance/drop decision and refill gating
    always_comb begin
        rise_c_s    = 1'b0;
        rise_s_s    = 1'b0;
        set_c_s     = 1'b0;
        set_s_s     = 1'b0;
        drop_c_s    = 1'b0;
        drop_s_s    = 1'b0;
        refill_ok_s = 1'b0;

        rise_c_s = bus.vend_coffee & ~vend_c_q_r;
        rise_s_s = bus.vend_sprite & ~vend_s_q_r;

        // Acceptance looks at the pre-load stock, so a same-edge refill cannot rescue a sold-out request
        if (rise_c_s) begin
            if ((stock_c_r != STOCK_NONE) && !pend_c_r) begin
                set_c_s = 1'b1;
            end else begin
                drop_c_s = 1'b1;
            end
        end else begin
            set_c_s  = 1'b0;
            drop_c_s = 1'b0;
        end

        if (rise_s_s) begin
            if ((stock_s_r != STOCK_NONE) && !pend_s_r) begin
                set_s_s = 1'b1;
            end else begin
                drop_s_s = 1'b1;
            end
        end else begin
            set_s_s  = 1'b0;
            drop_s_s = 1'b0;
        end

        if ((state_r == ST_IDLE) && !pend_c_r && !pend_s_r && bus.refill) begin
            refill_ok_s = 1'b1;
        end else begin
            refill_ok_s = 1'b0;
        end
    end

    // Next-state and run/gap tick counter; coffee wins when both products are pending
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        take_c_s     = 1'b0;
        take_s_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pend_c_r) begin
                    state_next_s = ST_RUN_C;
                    tick_next_s  = {TICK_W{1'b0}};
                    take_c_s     = 1'b1;
                end else if (pend_s_r) begin
                    state_next_s = ST_RUN_S;
                    tick_next_s  = {TICK_W{1'b0}};
                    take_s_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                    tick_next_s  = {TICK_W{1'b0}};
                end
            end
            ST_RUN_C, ST_RUN_S: begin
                if (tick_r == RUN_LAST) begin
                    state_next_s = ST_GAP;
                    tick_next_s  = {TICK_W{1'b0}};
                end else begin
                    tick_next_s  = tick_r + TICK_W'(1);
                end
            end
            ST_GAP: begin
                if (tick_r == GAP_LAST) begin
                    state_next_s = ST_IDLE;
                    tick_next_s  = {TICK_W{1'b0}};
                end else begin
                    tick_next_s  = tick_r + TICK_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                tick_next_s  = {TICK_W{1'b0}};
            end
        endcase
    end

    // State register and tick counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            tick_r  <= {TICK_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            tick_r  <= tick_next_s;
        end
    end

    // Request history, pend flags, stock counters, motor drive and drop pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            vend_c_q_r <= 1'b0;
            vend_s_q_r <= 1'b0;
            pend_c_r   <= 1'b0;
            pend_s_r   <= 1'b0;
            stock_c_r  <= STOCK_LOAD;
            stock_s_r  <= STOCK_LOAD;
            motor_c_r  <= 1'b0;
            motor_s_r  <= 1'b0;
            drop_err_r <= 1'b0;
        end else begin
            vend_c_q_r <= bus.vend_coffee;
            vend_s_q_r <= bus.vend_sprite;

            if (take_c_s) begin
                pend_c_r <= 1'b0;
            end else if (set_c_s) begin
                pend_c_r <= 1'b1;
            end

            if (take_s_s) begin
                pend_s_r <= 1'b0;
            end else if (set_s_s) begin
                pend_s_r <= 1'b1;
            end

            // Refill and a take are mutually exclusive: refill requires no pend, a take requires one
            if (refill_ok_s) begin
                stock_c_r <= STOCK_LOAD;
                stock_s_r <= STOCK_LOAD;
            end else begin
                if (take_c_s) begin
                    stock_c_r <= stock_c_r - STOCK_ONE;
                end
                if (take_s_s) begin
                    stock_s_r <= stock_s_r - STOCK_ONE;
                end
            end

            motor_c_r  <= (state_next_s == ST_RUN_C);
            motor_s_r  <= (state_next_s == ST_RUN_S);
            drop_err_r <= drop_c_s | drop_s_s;
        end
    end

    assign bus.motor_coffee = motor_c_r;
    assign bus.motor_sprite = motor_s_r;
    assign bus.drop_err     = drop_err_r;
    assign bus.stock_coffee = stock_c_r;
    assign bus.stock_sprite = stock_s_r;
    assign bus.sold_out     = {(stock_s_r == STOCK_NONE), (stock_c_r == STOCK_NONE)};
    assign bus.busy         = (state_r != ST_IDLE) | pend_c_r | pend_s_r;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser with RUN_TICKS=4, GAP_TICKS=2, STOCK_INIT=2:
// a per-cycle vector table followed by hand-written over-queue and reset-mid-run sequences.
module tb_vend_dispenser;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    vend_dispenser_if #(.STOCK_W(4)) bus ();

    vend_dispenser #(
        .RUN_TICKS (4),
        .GAP_TICKS (2),
        .STOCK_INIT(2),
        .STOCK_W   (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       rst;
        logic       vc;
        logic       vs;
        logic       rf;
        logic       mc;
        logic       ms;
        logic       busy;
        logic       drop;
        logic [3:0] sc;
        logic [3:0] ss;
        logic [1:0] so;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic vc, input logic vs, input logic rf,
                       input logic mc, input logic ms, input logic busy, input logic drop,
                       input logic [3:0] sc, input logic [3:0] ss, input logic [1:0] so);
        vec_t v;
        v.rst = rst; v.vc = vc; v.vs = vs; v.rf = rf;
        v.mc = mc; v.ms = ms; v.busy = busy; v.drop = drop;
        v.sc = sc; v.ss = ss; v.so = so;
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, then settle just after the rising edge
    task automatic step(input logic rst, input logic vc, input logic vs, input logic rf);
        @(negedge clock);
        reset           = rst;
        bus.vend_coffee = vc;
        bus.vend_sprite = vs;
        bus.refill      = rf;
        @(posedge clock);
        #1;
        chk("no_overlap", {15'd0, bus.motor_coffee & bus.motor_sprite}, 16'd0);
    endtask

    initial begin
        clock           = 1'b0;
        reset           = 1'b0;
        bus.vend_coffee = 1'b0;
        bus.vend_sprite = 1'b0;
        bus.refill      = 1'b0;
        checks          = 0;
        failures        = 0;

        //   rst vc vs rf | mc ms bsy drp sc ss so
        // reset, then single coffee vend (level held 3 cycles)
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 2'b00);
        // refill in IDLE restores coffee
        add(1'b1, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 2'b00);
        // simultaneous rise; refill during RUN_C is ignored
        add(1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 2'b00);
        add(1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 2'b00);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 2'b00);
        for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 2'b00);
        // coffee sells out, then a request against zero stock is dropped
        add(1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 2'b00);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'b01);
        for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'b01);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b01);
        add(1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 2'b01);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b01);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b01);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].vc, vecs[i].vs, vecs[i].rf);
            chk($sformatf("row%0d_motor_coffee", i), {15'd0, bus.motor_coffee}, {15'd0, vecs[i].mc});
            chk($sformatf("row%0d_motor_sprite", i), {15'd0, bus.motor_sprite}, {15'd0, vecs[i].ms});
            chk($sformatf("row%0d_busy", i),         {15'd0, bus.busy},         {15'd0, vecs[i].busy});
            chk($sformatf("row%0d_drop_err", i),     {15'd0, bus.drop_err},     {15'd0, vecs[i].drop});
            chk($sformatf("row%0d_stock_coffee", i), {12'd0, bus.stock_coffee}, {12'd0, vecs[i].sc});
            chk($sformatf("row%0d_stock_sprite", i), {12'd0, bus.stock_sprite}, {12'd0, vecs[i].ss});
            chk($sformatf("row%0d_sold_out", i),     {14'd0, bus.sold_out},     {14'd0, vecs[i].so});
        end

        // Over-queue: second sprite rise during RUN_S is dropped, first is served after GAP
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("oq_refill_sc", {12'd0, bus.stock_coffee}, 16'd2);
        chk("oq_refill_ss", {12'd0, bus.stock_sprite}, 16'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("oq_pend_busy", {15'd0, bus.busy}, 16'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("oq_run_ms", {15'd0, bus.motor_sprite}, 16'd1);
        chk("oq_run_ss", {12'd0, bus.stock_sprite}, 16'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("oq_first_rise_drop", {15'd0, bus.drop_err}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("oq_second_rise_drop", {15'd0, bus.drop_err}, 16'd1);
        chk("oq_second_rise_ms", {15'd0, bus.motor_sprite}, 16'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("oq_gap_ms", {15'd0, bus.motor_sprite}, 16'd0);
        chk("oq_gap_drop", {15'd0, bus.drop_err}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("oq_idle_pending_busy", {15'd0, bus.busy}, 16'd1);
        chk("oq_idle_pending_ms", {15'd0, bus.motor_sprite}, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("oq_second_run_ms", {15'd0, bus.motor_sprite}, 16'd1);
        chk("oq_second_run_ss", {12'd0, bus.stock_sprite}, 16'd0);
        chk("oq_sold_out", {14'd0, bus.sold_out}, 16'd2);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("oq_done_busy", {15'd0, bus.busy}, 16'd0);

        // Reset asserted on the second motor cycle
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rm_refill_so", {14'd0, bus.sold_out}, 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rm_run_mc", {15'd0, bus.motor_coffee}, 16'd1);
        chk("rm_run_sc", {12'd0, bus.stock_coffee}, 16'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rm_reset_mc", {15'd0, bus.motor_coffee}, 16'd0);
        chk("rm_reset_busy", {15'd0, bus.busy}, 16'd0);
        chk("rm_reset_sc", {12'd0, bus.stock_coffee}, 16'd2);
        chk("rm_reset_ss", {12'd0, bus.stock_sprite}, 16'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rm_after_mc", {15'd0, bus.motor_coffee}, 16'd0);
        chk("rm_after_busy", {15'd0, bus.busy}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
